// File: rtl/aes_inv_sbox_iter.sv
// Iterative inverse AES S-box over four byte lanes.
// Each lane applies the inverse affine map, then raises the result to x^254 in GF(2^8) over seven cycles.
module aes_inv_sbox_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] sboxw,
  output logic        ready,
  output logic        result_valid,
  output logic [31:0] new_sboxw
);

  typedef enum logic {IDLE, EXP} state_t;

  state_t      state_reg;
  logic [31:0] sq_reg;
  logic [31:0] acc_reg;
  logic [2:0]  cnt_reg;
  logic        ready_reg;
  logic        result_valid_reg;
  logic [31:0] new_sboxw_reg;

  logic [31:0] aff_next;
  logic [31:0] sq_next;
  logic [31:0] acc_next;

  // GF(2^8) multiply, reduced modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // Squaring reuses the general multiplier; x^254 maps zero to zero without a special case.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign aff_next[gi*8 +: 8] = inv_affine(sboxw[gi*8 +: 8]);
    assign sq_next[gi*8 +: 8]  = gf_mul(sq_reg[gi*8 +: 8], sq_reg[gi*8 +: 8]);
    assign acc_next[gi*8 +: 8] = gf_mul(acc_reg[gi*8 +: 8], sq_next[gi*8 +: 8]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      sq_reg           <= 32'h0;
      acc_reg          <= 32'h0;
      cnt_reg          <= 3'd0;
      ready_reg        <= 1'b1;
      result_valid_reg <= 1'b0;
      new_sboxw_reg    <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sq_reg           <= aff_next;
            acc_reg          <= 32'h01010101;
            cnt_reg          <= 3'd0;
            state_reg        <= EXP;
            ready_reg        <= 1'b0;
            result_valid_reg <= 1'b0;
          end
        end
        EXP: begin
          sq_reg  <= sq_next;
          acc_reg <= acc_next;
          // Seventh step: acc_next now holds x^2 * x^4 * ... * x^128.
          if (cnt_reg == 3'd6) begin
            cnt_reg          <= 3'd0;
            new_sboxw_reg    <= acc_next;
            result_valid_reg <= 1'b1;
            ready_reg        <= 1'b1;
            state_reg        <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready        = ready_reg;
  assign result_valid = result_valid_reg;
  assign new_sboxw    = new_sboxw_reg;

endmodule

// File: tb/tb_aes_inv_sbox_iter.sv
// Directed bench for aes_inv_sbox_iter: reset, known vectors, latency, busy protocol,
// mid-operation reset, idle hold and a full round trip through the forward S-box.
module tb_aes_inv_sbox_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] sboxw;
  logic        ready;
  logic        result_valid;
  logic [31:0] new_sboxw;

  int errors = 0;
  int checks = 0;

  aes_inv_sbox_iter dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sboxw        (sboxw),
    .ready        (ready),
    .result_valid (result_valid),
    .new_sboxw    (new_sboxw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for edge E0, then run E1..E7.
  task automatic do_request(input logic [31:0] w);
    start = 1'b1;
    sboxw = w;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
  endtask

  // Carry-less product, reduced afterwards by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int y = 1; y < 256; y++)
      if (ref_mul(b, 8'(y)) == 8'h01) r = 8'(y);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ref_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    sboxw = 32'h637c16ed;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    checks++;
    if (new_sboxw !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", new_sboxw); end
    tick();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_start_ignored ready got=%b exp=1", ready); end
    $display("test_reset: ready=%b valid=%b data=%h", ready, result_valid, new_sboxw);
  endtask

  task automatic test_known(input logic [31:0] w, input logic [31:0] exp);
    start = 1'b1;
    sboxw = w;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (ready !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early in=%h ready=%b valid=%b exp ready=0 valid=0", w, ready, result_valid);
    end
    tick();
    checks++;
    if (new_sboxw !== exp || result_valid !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL known in=%h got=%h valid=%b ready=%b exp=%h valid=1 ready=1",
               w, new_sboxw, result_valid, ready, exp);
    end
    $display("test_known: in=%h out=%h", w, new_sboxw);
  endtask

  task automatic test_round_trip();
    logic [7:0]  s;
    logic [31:0] exp;
    for (int b = 0; b < 256; b++) begin
      s   = fwd_sbox(8'(b));
      exp = {4{8'(b)}};
      do_request({4{s}});
      checks++;
      if (new_sboxw !== exp || result_valid !== 1'b1) begin
        errors++;
        $display("FAIL round_trip in=%h got=%h valid=%b exp=%h", {4{s}}, new_sboxw, result_valid, exp);
      end
      $display("round_trip: in=%h out=%h", {4{s}}, new_sboxw);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    sboxw = 32'h637c16ed;
    tick();                                  // E0
    start = 1'b0;
    tick();                                  // E1
    tick();                                  // E2
    start = 1'b1;
    sboxw = 32'hffffffff;
    tick();                                  // E3, busy so ignored
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", ready); end
    for (int i = 0; i < 4; i++) tick();      // E4..E7
    checks++;
    if (new_sboxw !== 32'h0001ff53 || ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignored got=%h ready=%b exp=0001ff53 ready=1", new_sboxw, ready);
    end
    start = 1'b1;
    sboxw = 32'h52525252;
    tick();                                  // E8
    start = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || ready !== 1'b0 || new_sboxw !== 32'h0001ff53) begin
      errors++;
      $display("FAIL b2b_accept valid=%b ready=%b data=%h exp valid=0 ready=0 data=0001ff53",
               result_valid, ready, new_sboxw);
    end
    for (int i = 0; i < 6; i++) tick();      // E9..E14
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b_early ready=%b exp=0", ready); end
    tick();                                  // E15
    checks++;
    if (new_sboxw !== 32'h48484848 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result got=%h valid=%b exp=48484848 valid=1", new_sboxw, result_valid);
    end
    $display("test_back_to_back: out=%h", new_sboxw);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    sboxw = 32'h637c16ed;
    tick();                                  // E0
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();      // E1..E3
    reset = 1'b1;
    tick();                                  // E4
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || result_valid !== 1'b0 || new_sboxw !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid ready=%b valid=%b data=%h exp ready=1 valid=0 data=00000000",
               ready, result_valid, new_sboxw);
    end
    do_request(32'h00637c16);
    checks++;
    if (new_sboxw !== 32'h520001ff || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next got=%h valid=%b exp=520001ff", new_sboxw, result_valid);
    end
    $display("test_reset_mid: out=%h", new_sboxw);
  endtask

  task automatic test_idle_hold();
    logic [31:0] held;
    do_request(32'h52525252);
    held = 32'h48484848;
    for (int i = 0; i < 20; i++) begin
      sboxw = $urandom;
      tick();
      checks++;
      if (new_sboxw !== held || result_valid !== 1'b1 || ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold cycle=%0d got=%h valid=%b ready=%b exp=%h",
                 i, new_sboxw, result_valid, ready, held);
      end
    end
    $display("test_idle_hold: out=%h", new_sboxw);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sboxw = 32'h0;
    test_reset();
    test_known(32'h637c16ed, 32'h0001ff53);
    test_known(32'h00000000, 32'h52525252);
    test_known(32'h00637c16, 32'h520001ff);
    test_round_trip();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
